// File: rtl/kf_dma_pkg.sv
// Shared definitions for the KF DMA CPU-side bus interface: control-block
// register offsets and the write-session state encoding.
package kf_dma_pkg;

  localparam int unsigned OFS_COMMAND            = 0;
  localparam int unsigned OFS_REQUEST            = 1;
  localparam int unsigned OFS_SINGLE_MASK        = 2;
  localparam int unsigned OFS_MODE               = 3;
  localparam int unsigned OFS_CLEAR_BYTE_POINTER = 4;
  localparam int unsigned OFS_MASTER_CLEAR       = 5;
  localparam int unsigned OFS_CLEAR_MASK         = 6;
  localparam int unsigned OFS_WRITE_ALL_MASK     = 7;

  typedef enum logic [0:0] {
    WR_IDLE,
    WR_WRITE
  } write_state_t;

endpackage

// File: rtl/kf_dma_bus_control_if.sv
// CPU bus / register-file signal bundle for kf_dma_bus_control.
// Page register ports exist only when KF_DMA_PAGE_REGISTER_EN is defined.
interface kf_dma_bus_control_if #(
  parameter int CHANNELS = 4
);
  localparam int ADDR_WIDTH = $clog2(2 * CHANNELS) + 1;

  logic                  chip_select_n;
  logic                  io_read_n_in;
  logic                  io_write_n_in;
  logic [ADDR_WIDTH-1:0] address_in;
  logic [7:0]            data_bus_in;
  logic                  lock_bus_control;

  logic [7:0]            internal_data_bus;
  logic                  write_command_register;
  logic                  write_mode_register;
  logic                  write_request_register;
  logic                  set_or_reset_mask_register;
  logic                  write_mask_register;
  logic                  master_clear;
  logic                  clear_mask_register;
  logic [CHANNELS-1:0]   write_base_and_current_address;
  logic [CHANNELS-1:0]   write_base_and_current_word_count;
  logic                  read_status_register;
  logic                  read_temporary_register;
  logic [CHANNELS-1:0]   read_current_address;
  logic [CHANNELS-1:0]   read_current_word_count;
  logic                  byte_pointer;
`ifdef KF_DMA_PAGE_REGISTER_EN
  logic                  page_chip_select_n;
  logic [CHANNELS*8-1:0] page_address;
  logic [7:0]            page_read_data;
`endif

  modport master (
    output chip_select_n, io_read_n_in, io_write_n_in, address_in, data_bus_in,
           lock_bus_control,
    input  internal_data_bus, write_command_register, write_mode_register,
           write_request_register, set_or_reset_mask_register, write_mask_register,
           master_clear, clear_mask_register, write_base_and_current_address,
           write_base_and_current_word_count, read_status_register,
           read_temporary_register, read_current_address, read_current_word_count,
           byte_pointer
`ifdef KF_DMA_PAGE_REGISTER_EN
    , output page_chip_select_n
    , input  page_address, page_read_data
`endif
  );

  modport slave (
    input  chip_select_n, io_read_n_in, io_write_n_in, address_in, data_bus_in,
           lock_bus_control,
    output internal_data_bus, write_command_register, write_mode_register,
           write_request_register, set_or_reset_mask_register, write_mask_register,
           master_clear, clear_mask_register, write_base_and_current_address,
           write_base_and_current_word_count, read_status_register,
           read_temporary_register, read_current_address, read_current_word_count,
           byte_pointer
`ifdef KF_DMA_PAGE_REGISTER_EN
    , input  page_chip_select_n
    , output page_address, page_read_data
`endif
  );

endinterface

// File: rtl/kf_dma_strobe_capture.sv
// Write-session FSM: captures data/address while the write strobe is low and
// flags completion (combinationally) on the clock that sees the strobe high again.
module kf_dma_strobe_capture
  import kf_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  select_n,
  input  logic                  io_read_n_in,
  input  logic                  io_write_n_in,
  input  logic                  lock_bus_control,
  input  logic [7:0]            data_bus_in,
  input  logic [ADDR_WIDTH-1:0] address_in,
  output logic [7:0]            data,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  complete
);

  write_state_t state, state_next;
  logic         capture;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= WR_IDLE;
      data    <= '0;
      address <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        data    <= data_bus_in;
        address <= address_in;
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      WR_IDLE: begin
        if (!select_n && !lock_bus_control && !io_write_n_in && io_read_n_in) begin
          state_next = WR_WRITE;
          capture    = 1'b1;
        end
      end
      WR_WRITE: begin
        if (select_n || lock_bus_control) begin
          state_next = WR_IDLE;
        end else if (io_write_n_in) begin
          state_next = WR_IDLE;
          complete   = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      default: state_next = WR_IDLE;
    endcase
  end

endmodule

// File: rtl/kf_dma_bus_control.sv
// KF DMA CPU-side bus control: register decode, registered write strobes,
// read selects and the byte pointer. Optional page registers: KF_DMA_PAGE_REGISTER_EN.
module kf_dma_bus_control
  import kf_dma_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input logic                 clock,
  input logic                 reset,
  kf_dma_bus_control_if.slave bus
);

  localparam int          ADDR_WIDTH = $clog2(2 * CHANNELS) + 1;
  localparam int unsigned BASE       = 2 ** (ADDR_WIDTH - 1);
  localparam int unsigned CHAN_LIMIT = 2 * CHANNELS;

  function automatic logic is_ctrl(input logic [ADDR_WIDTH-1:0] a, input int unsigned ofs);
    return (32'(a) >= BASE) && ((32'(a) - BASE) == ofs);
  endfunction

  function automatic logic is_chan(input logic [ADDR_WIDTH-1:0] a, input int unsigned ch,
                                   input logic lsb);
    return (32'(a) < CHAN_LIMIT) && (32'(a >> 1) == ch) && (a[0] == lsb);
  endfunction

  logic [7:0]            write_data;
  logic [ADDR_WIDTH-1:0] write_address;
  logic                  write_complete;

  kf_dma_strobe_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_capture (
    .clock            (clock),
    .reset            (reset),
    .select_n         (bus.chip_select_n),
    .io_read_n_in     (bus.io_read_n_in),
    .io_write_n_in    (bus.io_write_n_in),
    .lock_bus_control (bus.lock_bus_control),
    .data_bus_in      (bus.data_bus_in),
    .address_in       (bus.address_in),
    .data             (write_data),
    .address          (write_address),
    .complete         (write_complete)
  );

  assign bus.internal_data_bus = write_data;

  logic                  read_valid, read_active, read_complete;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [CHANNELS-1:0]   wr_addr_next, wr_count_next;
  logic                  clear_pointer, toggle_pointer;

  assign read_valid    = !bus.chip_select_n && !bus.lock_bus_control &&
                         !bus.io_read_n_in && bus.io_write_n_in;
  // Read completes on the first clock that sees the strobe released inside a live session.
  assign read_complete = read_active && bus.io_read_n_in &&
                         !bus.chip_select_n && !bus.lock_bus_control;

  assign bus.read_status_register    = read_valid && is_ctrl(bus.address_in, OFS_COMMAND);
  assign bus.read_temporary_register = read_valid && is_ctrl(bus.address_in, OFS_MASTER_CLEAR);

  always_comb begin
    wr_addr_next                 = '0;
    wr_count_next                = '0;
    bus.read_current_address     = '0;
    bus.read_current_word_count  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_addr_next[i]                = write_complete && is_chan(write_address, i, 1'b0);
      wr_count_next[i]               = write_complete && is_chan(write_address, i, 1'b1);
      bus.read_current_address[i]    = read_valid && is_chan(bus.address_in, i, 1'b0);
      bus.read_current_word_count[i] = read_valid && is_chan(bus.address_in, i, 1'b1);
    end
    toggle_pointer = (write_complete && (32'(write_address) < CHAN_LIMIT)) ||
                     (read_complete && (32'(read_address) < CHAN_LIMIT));
    clear_pointer  = write_complete && (is_ctrl(write_address, OFS_CLEAR_BYTE_POINTER) ||
                                        is_ctrl(write_address, OFS_MASTER_CLEAR));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.write_command_register            <= 1'b0;
      bus.write_mode_register               <= 1'b0;
      bus.write_request_register            <= 1'b0;
      bus.set_or_reset_mask_register        <= 1'b0;
      bus.write_mask_register               <= 1'b0;
      bus.master_clear                      <= 1'b0;
      bus.clear_mask_register               <= 1'b0;
      bus.write_base_and_current_address    <= '0;
      bus.write_base_and_current_word_count <= '0;
      bus.byte_pointer                      <= 1'b0;
      read_active                           <= 1'b0;
      read_address                          <= '0;
    end else begin
      bus.write_command_register            <= write_complete && is_ctrl(write_address, OFS_COMMAND);
      bus.write_request_register            <= write_complete && is_ctrl(write_address, OFS_REQUEST);
      bus.set_or_reset_mask_register        <= write_complete && is_ctrl(write_address, OFS_SINGLE_MASK);
      bus.write_mode_register               <= write_complete && is_ctrl(write_address, OFS_MODE);
      bus.master_clear                      <= write_complete && is_ctrl(write_address, OFS_MASTER_CLEAR);
      bus.clear_mask_register               <= write_complete && is_ctrl(write_address, OFS_CLEAR_MASK);
      bus.write_mask_register               <= write_complete && is_ctrl(write_address, OFS_WRITE_ALL_MASK);
      bus.write_base_and_current_address    <= wr_addr_next;
      bus.write_base_and_current_word_count <= wr_count_next;
      read_active                           <= read_valid;
      if (read_valid) read_address <= bus.address_in;
      if (clear_pointer)       bus.byte_pointer <= 1'b0;
      else if (toggle_pointer) bus.byte_pointer <= !bus.byte_pointer;
    end
  end

`ifdef KF_DMA_PAGE_REGISTER_EN
  logic [7:0]            page_write_data;
  logic [ADDR_WIDTH-1:0] page_write_address;
  logic                  page_complete, page_read_valid;

  kf_dma_strobe_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_page_capture (
    .clock            (clock),
    .reset            (reset),
    .select_n         (bus.page_chip_select_n),
    .io_read_n_in     (bus.io_read_n_in),
    .io_write_n_in    (bus.io_write_n_in),
    .lock_bus_control (bus.lock_bus_control),
    .data_bus_in      (bus.data_bus_in),
    .address_in       (bus.address_in),
    .data             (page_write_data),
    .address          (page_write_address),
    .complete         (page_complete)
  );

  assign page_read_valid = !bus.page_chip_select_n && !bus.lock_bus_control &&
                           !bus.io_read_n_in && bus.io_write_n_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.page_address <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (page_complete && (32'(page_write_address) == i))
          bus.page_address[i*8 +: 8] <= page_write_data;
      end
    end
  end

  always_comb begin
    bus.page_read_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (page_read_valid && (32'(bus.address_in) == i))
        bus.page_read_data = bus.page_address[i*8 +: 8];
    end
  end
`endif

endmodule

// File: tb/tb_kf_dma_bus_control.sv
// Directed self-checking bench for kf_dma_bus_control (4- and 8-channel builds);
// page register checks are included when KF_DMA_PAGE_REGISTER_EN is defined.
module tb_kf_dma_bus_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  kf_dma_bus_control_if #(.CHANNELS(4)) if4 ();
  kf_dma_bus_control_if #(.CHANNELS(8)) if8 ();

  kf_dma_bus_control #(.CHANNELS(4)) dut4 (.clock(clock), .reset(reset), .bus(if4.slave));
  kf_dma_bus_control #(.CHANNELS(8)) dut8 (.clock(clock), .reset(reset), .bus(if8.slave));

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [14:0] strobes;
    logic        bp;
  } vec_t;

  vec_t vecs[15];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {cmd, mode, req, single_mask, all_mask, master_clear, clear_mask, wa[3:0], wc[3:0]}
  function automatic logic [14:0] strobes4();
    return {if4.write_command_register, if4.write_mode_register, if4.write_request_register,
            if4.set_or_reset_mask_register, if4.write_mask_register, if4.master_clear,
            if4.clear_mask_register, if4.write_base_and_current_address,
            if4.write_base_and_current_word_count};
  endfunction

  function automatic logic [22:0] strobes8();
    return {if8.write_command_register, if8.write_mode_register, if8.write_request_register,
            if8.set_or_reset_mask_register, if8.write_mask_register, if8.master_clear,
            if8.clear_mask_register, if8.write_base_and_current_address,
            if8.write_base_and_current_word_count};
  endfunction

  task automatic start_write4(input logic [3:0] a, input logic [7:0] d);
    @(negedge clock);
    if4.chip_select_n = 1'b0;
    if4.address_in    = a;
    if4.data_bus_in   = d;
    if4.io_write_n_in = 1'b0;
    @(negedge clock);
  endtask

  // Release the strobe, scramble bus data/address, land just after edge k.
  task automatic end_write4();
    if4.io_write_n_in = 1'b1;
    if4.data_bus_in   = ~if4.data_bus_in;
    if4.address_in    = 4'h8;
    @(posedge clock); #1;
  endtask

  task automatic idle4();
    @(negedge clock);
    if4.chip_select_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic write8(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    if8.chip_select_n = 1'b0;
    if8.address_in    = a;
    if8.data_bus_in   = d;
    if8.io_write_n_in = 1'b0;
    @(negedge clock);
    if8.io_write_n_in = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    if4.chip_select_n = 1'b1; if4.io_read_n_in = 1'b1; if4.io_write_n_in = 1'b1;
    if4.address_in = '0; if4.data_bus_in = '0; if4.lock_bus_control = 1'b0;
    if8.chip_select_n = 1'b1; if8.io_read_n_in = 1'b1; if8.io_write_n_in = 1'b1;
    if8.address_in = '0; if8.data_bus_in = '0; if8.lock_bus_control = 1'b0;
`ifdef KF_DMA_PAGE_REGISTER_EN
    if4.page_chip_select_n = 1'b1;
    if8.page_chip_select_n = 1'b1;
`endif

    vecs[0]  = '{4'h0, 8'h11, 15'h0010, 1'b1};
    vecs[1]  = '{4'h0, 8'h22, 15'h0010, 1'b0};
    vecs[2]  = '{4'hC, 8'h33, 15'h0000, 1'b0};
    vecs[3]  = '{4'h3, 8'h5A, 15'h0002, 1'b1};
    vecs[4]  = '{4'h6, 8'h44, 15'h0080, 1'b0};
    vecs[5]  = '{4'h8, 8'h55, 15'h4000, 1'b0};
    vecs[6]  = '{4'h5, 8'h66, 15'h0004, 1'b1};
    vecs[7]  = '{4'hB, 8'h67, 15'h2000, 1'b1};
    vecs[8]  = '{4'h9, 8'h68, 15'h1000, 1'b1};
    vecs[9]  = '{4'hA, 8'h69, 15'h0800, 1'b1};
    vecs[10] = '{4'hF, 8'h6A, 15'h0400, 1'b1};
    vecs[11] = '{4'hE, 8'h6B, 15'h0100, 1'b1};
    vecs[12] = '{4'hD, 8'h6C, 15'h0200, 1'b0};
    vecs[13] = '{4'h7, 8'h77, 15'h0008, 1'b1};
    vecs[14] = '{4'h1, 8'h78, 15'h0001, 1'b0};

    repeat (2) @(negedge clock);
    check("reset_strobes", 32'(strobes4()), 0);
    check("reset_data", 32'(if4.internal_data_bus), 0);
    check("reset_bp", 32'(if4.byte_pointer), 0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      start_write4(vecs[i].addr, vecs[i].data);
      end_write4();
      check($sformatf("vec%0d_strobes", i), 32'(strobes4()), 32'(vecs[i].strobes));
      check($sformatf("vec%0d_data", i), 32'(if4.internal_data_bus), 32'(vecs[i].data));
      check($sformatf("vec%0d_bp", i), 32'(if4.byte_pointer), 32'(vecs[i].bp));
      idle4();
      check($sformatf("vec%0d_one_cycle", i), 32'(strobes4()), 0);
      check($sformatf("vec%0d_data_hold", i), 32'(if4.internal_data_bus), 32'(vecs[i].data));
    end

    // Abort by chip select rising while the write is still low.
    start_write4(4'h0, 8'hAA);
    if4.chip_select_n = 1'b1;
    @(negedge clock); if4.io_write_n_in = 1'b1;
    @(posedge clock); #1;
    check("abort_cs_strobes", 32'(strobes4()), 0);
    @(posedge clock); #1;
    check("abort_cs_strobes2", 32'(strobes4()), 0);
    check("abort_cs_bp", 32'(if4.byte_pointer), 0);

    // Abort by the DMA taking the bus.
    start_write4(4'h0, 8'hBB);
    if4.lock_bus_control = 1'b1;
    @(negedge clock); if4.io_write_n_in = 1'b1;
    @(posedge clock); #1;
    check("abort_lock_strobes", 32'(strobes4()), 0);
    @(negedge clock); if4.lock_bus_control = 1'b0; if4.chip_select_n = 1'b1;
    @(posedge clock); #1;
    check("abort_lock_strobes2", 32'(strobes4()), 0);
    check("abort_lock_bp", 32'(if4.byte_pointer), 0);

    start_write4(4'h2, 8'h3C);
    end_write4();
    check("post_abort_strobes", 32'(strobes4()), 32'h0020);
    check("post_abort_data", 32'(if4.internal_data_bus), 32'h3C);
    check("post_abort_bp", 32'(if4.byte_pointer), 1);
    idle4();

    // Channel 2 count read held for three clocks.
    @(negedge clock);
    if4.chip_select_n = 1'b0; if4.address_in = 4'h5; if4.io_read_n_in = 1'b0;
    #1;
    check("read_sel_comb", 32'(if4.read_current_word_count), 32'b0100);
    check("read_sel_addr", 32'(if4.read_current_address), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check($sformatf("read_sel_cyc%0d", k), 32'(if4.read_current_word_count), 32'b0100);
      check($sformatf("read_bp_hold%0d", k), 32'(if4.byte_pointer), 1);
    end
    @(negedge clock); if4.io_read_n_in = 1'b1;
    #1;
    check("read_sel_off", 32'(if4.read_current_word_count), 0);
    @(posedge clock); #1;
    check("read_bp_toggle", 32'(if4.byte_pointer), 0);
    @(posedge clock); #1;
    check("read_bp_once", 32'(if4.byte_pointer), 0);

    // Control-block reads do not move the byte pointer.
    @(negedge clock); if4.address_in = 4'h8; if4.io_read_n_in = 1'b0;
    #1;
    check("read_status", 32'(if4.read_status_register), 1);
    check("read_status_temp", 32'(if4.read_temporary_register), 0);
    if4.address_in = 4'hD;
    #1;
    check("read_temp", 32'(if4.read_temporary_register), 1);
    check("read_temp_status", 32'(if4.read_status_register), 0);
    @(negedge clock); if4.io_read_n_in = 1'b1;
    @(posedge clock); #1;
    check("ctrl_read_bp", 32'(if4.byte_pointer), 0);

    // Both strobes low: nothing happens.
    @(negedge clock); if4.address_in = 4'h5; if4.io_read_n_in = 1'b0; if4.io_write_n_in = 1'b0;
    #1;
    check("both_low_rsel", 32'(if4.read_current_word_count), 0);
    @(negedge clock); if4.io_read_n_in = 1'b1; if4.io_write_n_in = 1'b1;
    @(posedge clock); #1;
    check("both_low_strobes", 32'(strobes4()), 0);
    @(posedge clock); #1;
    check("both_low_bp", 32'(if4.byte_pointer), 0);
    idle4();

    // Reset in the middle of a write.
    start_write4(4'h4, 8'h81);
    end_write4();
    check("pre_reset_strobes", 32'(strobes4()), 32'h0040);
    check("pre_reset_bp", 32'(if4.byte_pointer), 1);
    idle4();
    start_write4(4'h5, 8'hC3);
    reset = 1'b1;
    #1;
    check("mid_reset_bp", 32'(if4.byte_pointer), 0);
    check("mid_reset_data", 32'(if4.internal_data_bus), 0);
    @(negedge clock); if4.io_write_n_in = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("post_reset_strobes", 32'(strobes4()), 0);
    @(posedge clock); #1;
    check("post_reset_strobes2", 32'(strobes4()), 0);
    check("post_reset_bp", 32'(if4.byte_pointer), 0);
    idle4();

    // Eight channels: base 0x10.
    write8(5'h13, 8'h01);
    check("ch8_mode", 32'(strobes8()), 32'h200000);
    check("ch8_mode_bp", 32'(if8.byte_pointer), 0);
    write8(5'h1B, 8'h02);
    check("ch8_outside", 32'(strobes8()), 0);
    write8(5'h0F, 8'h03);
    check("ch8_wc7", 32'(strobes8()), 32'h000080);
    check("ch8_wc7_bp", 32'(if8.byte_pointer), 1);
    check("ch8_data", 32'(if8.internal_data_bus), 32'h03);
    @(posedge clock); #1;
    check("ch8_one_cycle", 32'(strobes8()), 0);
    @(negedge clock); if8.chip_select_n = 1'b1;

`ifdef KF_DMA_PAGE_REGISTER_EN
    @(negedge clock);
    if4.page_chip_select_n = 1'b0; if4.address_in = 4'h2; if4.data_bus_in = 8'h12;
    if4.io_write_n_in = 1'b0;
    @(negedge clock); if4.io_write_n_in = 1'b1; if4.data_bus_in = 8'hEE;
    @(posedge clock); #1;
    check("page2", 32'(if4.page_address), 32'h0012_0000);
    check("page_no_main_strobe", 32'(strobes4()), 0);
    @(negedge clock); if4.io_read_n_in = 1'b0;
    #1;
    check("page_read", 32'(if4.page_read_data), 32'h12);
    @(negedge clock); if4.io_read_n_in = 1'b1; if4.page_chip_select_n = 1'b1;
    reset = 1'b1;
    #1;
    check("page_reset", 32'(if4.page_address), 0);
    @(negedge clock); reset = 1'b0;
`endif

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
